// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory stage: fnc3 access sizes and LSU state codes.
// Also used by the decoder and the EX/MEM register.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // An access is misaligned when its bytes straddle a word boundary.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3[1:0])
            2'b01:   m = (off == 2'b11);
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational byte-lane steering: store data/enables across two word beats,
// and load-byte extraction with sign/zero extension.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_fnc3,
    input  logic [55:0] ld_bytes,
    output logic [31:0] ld_data
);

    logic [3:0]  be_base;
    logic [31:0] wmask;
    logic [7:0]  be_wide;
    logic [63:0] data_wide;
    logic [31:0] win;

    // Store: build an 8-byte window so the high spill lands in beat 1's low lanes.
    always_comb begin
        case (st_size)
            2'b00: begin
                be_base = 4'b0001;
                wmask   = {24'b0, st_wdata[7:0]};
            end
            2'b01: begin
                be_base = 4'b0011;
                wmask   = {16'b0, st_wdata[15:0]};
            end
            default: begin
                be_base = 4'b1111;
                wmask   = st_wdata;
            end
        endcase
        be_wide   = {4'b0, be_base} << st_off;
        data_wide = {32'b0, wmask} << {st_off, 3'b000};
    end

    assign be0    = be_wide[3:0];
    assign be1    = be_wide[7:4];
    assign wdata0 = data_wide[31:0];
    assign wdata1 = data_wide[63:32];

    always_comb begin
        win = ld_bytes[{1'b0, ld_off, 3'b000} +: 32];
        case (ld_fnc3)
            F3_B:    ld_data = {{24{win[7]}}, win[7:0]};
            F3_H:    ld_data = {{16{win[15]}}, win[15:0]};
            F3_BU:   ld_data = {24'b0, win[7:0]};
            F3_HU:   ld_data = {16'b0, win[15:0]};
            default: ld_data = win;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a word-wide req/ack bus, splits
// misaligned accesses into two beats and stalls the pipeline until done.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  fnc3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        st_done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    logic [1:0]  state;
    logic        split_q;
    logic        is_load;
    logic [1:0]  ld_off;
    logic [2:0]  ld_fnc3;
    logic [3:0]  be0, be1, be1_q;
    logic [31:0] wdata0, wdata1, wdata1_q;
    logic [31:0] rlo;
    logic [31:0] ld_ext;
    logic [55:0] ld_bytes;
    logic        mis;
    logic        legal;

    assign mis   = f3_misaligned(fnc3, addr[1:0]);
    assign legal = f3_legal(fnc3) && !(memRead && memWrite) && !(memWrite && fnc3[2])
                   && !(mis && !SPLIT_EN);

    // Low during DONE so the EX/MEM register advances at the end of the pulse cycle.
    assign stall = ((state == ST_IDLE) && (memRead || memWrite))
                   || (state == ST_BEAT0) || (state == ST_BEAT1);

    // On the final beat of a split load, the first word was captured into rlo.
    assign ld_bytes = (state == ST_BEAT1) ? {bus_rdata[23:0], rlo} : {24'b0, bus_rdata};

    lsu_lane_align u_align (
        .st_off   (addr[1:0]),
        .st_size  (fnc3[1:0]),
        .st_wdata (wdata),
        .be0      (be0),
        .be1      (be1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ld_off   (ld_off),
        .ld_fnc3  (ld_fnc3),
        .ld_bytes (ld_bytes),
        .ld_data  (ld_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            be1_q     <= '0;
            wdata1_q  <= '0;
            rlo       <= '0;
            split_q   <= 1'b0;
            is_load   <= 1'b0;
            ld_off    <= '0;
            ld_fnc3   <= '0;
            ld_data   <= '0;
            ld_valid  <= 1'b0;
            st_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle; a branch below raises them for one cycle.
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (memRead || memWrite) begin
                        if (!legal) begin
                            state <= ST_DONE;
                            err   <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            bus_req   <= 1'b1;
                            bus_we    <= memWrite;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be0;
                            bus_wdata <= wdata0;
                            be1_q     <= be1;
                            wdata1_q  <= wdata1;
                            split_q   <= mis;
                            is_load   <= memRead;
                            ld_off    <= addr[1:0];
                            ld_fnc3   <= fnc3;
                        end
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (bus_ack) begin
                        if (state == ST_BEAT0 && split_q) begin
                            state     <= ST_BEAT1;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_be    <= be1_q;
                            bus_wdata <= wdata1_q;
                            rlo       <= bus_rdata;
                        end else begin
                            state     <= ST_DONE;
                            bus_req   <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_addr  <= '0;
                            bus_be    <= '0;
                            bus_wdata <= '0;
                            if (is_load) begin
                                ld_valid <= 1'b1;
                                ld_data  <= ld_ext;
                            end else begin
                                st_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: byte-level memory model, randomized
// bus latency, decoupled monitor for bus beats and completion pulses.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  fnc3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid, st_done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_stage_lsu #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .fnc3(fnc3),
        .addr(addr), .wdata(wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
        .st_done(st_done), .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [2:0]  kind;   // {ld_valid, st_done, err}
        logic [31:0] data;
    } comp_t;

    beat_t      beat_q[$];
    comp_t      comp_q[$];
    int         delay_q[$];
    logic [7:0] mem [logic [31:0]];
    int         compared = 0;
    int         mismatched = 0;
    bit         force_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        return {rd_byte(wa + 32'd3), rd_byte(wa + 32'd2), rd_byte(wa + 32'd1), rd_byte(wa)};
    endfunction

    task automatic poke_word(input logic [31:0] wa, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[wa + 32'(i)] = w[8*i +: 8];
    endtask

    function automatic int nbytes(input logic [2:0] f);
        if (f == F3_B || f == F3_BU) return 1;
        if (f == F3_H || f == F3_HU) return 2;
        return 4;
    endfunction

    // Reference model: walk the accessed bytes one by one, group them into the
    // words they fall in, and compute the load value from the byte memory.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input int d0, input int d1);
        int          n, sz, exp_stall, nbeats;
        bit          ok;
        comp_t       c;
        beat_t       b[2];
        logic [31:0] v;
        sz = nbytes(f);
        ok = (rd != wr) && (f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) && !(wr && f[2]);
        if (!ok) begin
            c.kind = 3'b001;
            c.data = '0;
            comp_q.push_back(c);
            exp_stall = 1;
        end else begin
            b[0] = '{addr: a & ~32'd3, be: 4'b0, we: wr, wdata: 32'b0};
            b[1] = '{addr: (a & ~32'd3) + 32'd4, be: 4'b0, we: wr, wdata: 32'b0};
            nbeats = 1;
            v = '0;
            for (int i = 0; i < sz; i++) begin
                logic [31:0] ba;
                int          k, lane;
                ba   = a + 32'(i);
                k    = ((ba & ~32'd3) == b[0].addr) ? 0 : 1;
                lane = int'(ba[1:0]);
                if (k == 1) nbeats = 2;
                b[k].be[lane] = 1'b1;
                if (wr) b[k].wdata[8*lane +: 8] = wd[8*i +: 8];
                else    v[8*i +: 8] = rd_byte(ba);
            end
            if (rd) begin
                if (f == F3_B) v = {{24{v[7]}}, v[7:0]};
                if (f == F3_H) v = {{16{v[15]}}, v[15:0]};
                c.kind = 3'b100;
                c.data = v;
            end else begin
                for (int i = 0; i < sz; i++) mem[a + 32'(i)] = wd[8*i +: 8];
                c.kind = 3'b010;
                c.data = '0;
            end
            comp_q.push_back(c);
            for (int k = 0; k < nbeats; k++) beat_q.push_back(b[k]);
            delay_q.push_back(d0);
            if (nbeats == 2) delay_q.push_back(d1);
            exp_stall = 1 + (d0 + 1) + ((nbeats == 2) ? (d1 + 1) : 0);
        end
        memRead  = rd;
        memWrite = wr;
        fnc3     = f;
        addr     = a;
        wdata    = wd;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        @(negedge clk);
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Bus responder: per-beat ack delay taken from delay_q, read data from the byte memory.
    initial begin
        bit in_beat;
        int left;
        in_beat   = 1'b0;
        left      = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (rst) begin
                in_beat = 1'b0;
            end else if (force_ack) begin
                bus_ack   = 1'b1;
                bus_rdata = $urandom;
            end else if (bus_req) begin
                if (!in_beat) begin
                    in_beat = 1'b1;
                    left    = 0;
                    if (delay_q.size() > 0) left = delay_q.pop_front();
                end
                if (left == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_word(bus_addr);
                    in_beat   = 1'b0;
                end else begin
                    left--;
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: compares every accepted beat and every completion pulse against the queues.
    initial begin
        logic        pv_req, pv_ack, pv_we, pv_pulse;
        logic [31:0] pv_addr, pv_wd;
        logic [3:0]  pv_be;
        beat_t       b;
        comp_t       c;
        pv_req = 1'b0; pv_ack = 1'b0; pv_we = 1'b0; pv_pulse = 1'b0;
        pv_addr = '0; pv_wd = '0; pv_be = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv_req   = 1'b0;
                pv_ack   = 1'b0;
                pv_pulse = 1'b0;
            end else begin
                if (bus_req && pv_req && !pv_ack) begin
                    check("hold_addr", bus_addr, pv_addr);
                    check("hold_be", 32'(bus_be), 32'(pv_be));
                    check("hold_we", 32'(bus_we), 32'(pv_we));
                    check("hold_wdata", bus_wdata, pv_wd);
                end
                if (bus_req && bus_ack) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 32'(bus_req & bus_ack), 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_addr", bus_addr, b.addr);
                        check("beat_be", 32'(bus_be), 32'(b.be));
                        check("beat_we", 32'(bus_we), 32'(b.we));
                        if (b.we) check("beat_wdata", bus_wdata, b.wdata);
                    end
                end
                if (ld_valid || st_done || err) begin
                    check("pulse_prev_cycle", 32'(pv_pulse), 32'd0);
                    if (comp_q.size() == 0) begin
                        check("unexpected_done", 32'({ld_valid, st_done, err}), 32'd0);
                    end else begin
                        c = comp_q.pop_front();
                        check("done_kind", 32'({ld_valid, st_done, err}), 32'(c.kind));
                        if (c.kind == 3'b100) check("ld_data", ld_data, c.data);
                    end
                end
                pv_req   = bus_req;
                pv_ack   = bus_ack;
                pv_we    = bus_we;
                pv_addr  = bus_addr;
                pv_be    = bus_be;
                pv_wd    = bus_wdata;
                pv_pulse = ld_valid | st_done | err;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, r;
        bit          rd, wr;
        logic [2:0]  f;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; fnc3 = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_pulses", 32'({ld_valid, st_done, err}), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);
        memRead = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall), 32'd1);
        memRead = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Directed cases
        poke_word(32'h100, 32'hDEADBEEF);
        issue(1, 0, F3_W, 32'h100, 32'h0, 0, 0);
        poke_word(32'h200, 32'h80FFFFFF);
        issue(1, 0, F3_B,  32'h203, 32'h0, 0, 0);
        issue(1, 0, F3_BU, 32'h203, 32'h0, 1, 0);
        issue(0, 1, F3_H,  32'h103, 32'h0000ABCD, 0, 0);
        poke_word(32'h100, 32'h11225566);
        poke_word(32'h104, 32'h77883344);
        issue(1, 0, F3_W, 32'h102, 32'h0, 3, 3);
        issue(1, 0, 3'b011, 32'h40, 32'h0, 0, 0);
        issue(1, 1, F3_W,  32'h40, 32'h12345678, 0, 0);
        issue(0, 1, F3_HU, 32'h40, 32'h12345678, 0, 0);
        issue(1, 0, F3_W,  32'hFFFFFFFE, 32'h0, 1, 2);
        issue(0, 1, F3_H,  32'hFFFFFFFF, 32'h00001234, 0, 0);
        issue(1, 0, F3_HU, 32'hFFFFFFFF, 32'h0, 0, 1);
        issue(1, 0, F3_H,  32'h103, 32'h0, 2, 0);

        // Randomized traffic over a small window plus the top-of-memory wrap region
        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 19);
            rd = (r < 9) || (r >= 18);
            wr = (r >= 9);
            f  = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                             : (32'h1000 + 32'($urandom_range(0, 63)));
            issue(rd, wr, f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the second beat of a split load, then a stray ack
        memRead = 1'b1; fnc3 = F3_W; addr = 32'h302; wdata = '0;
        beat_q.push_back('{addr: 32'h300, be: 4'b1100, we: 1'b0, wdata: 32'h0});
        delay_q.push_back(0);
        delay_q.push_back(500);
        #1;
        n = 0;
        while (!(bus_req === 1'b1 && bus_addr === 32'h304) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_test_beat1_addr", bus_addr, 32'h304);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req_drop", 32'(bus_req), 32'd0);
        check("rst_mid_no_ld_valid", 32'(ld_valid), 32'd0);
        memRead = 1'b0;
        beat_q.delete();
        comp_q.delete();
        delay_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("stray_ack_req", 32'(bus_req), 32'd0);
            check("stray_ack_pulses", 32'({ld_valid, st_done, err}), 32'd0);
            check("stray_ack_stall", 32'(stall), 32'd0);
        end
        force_ack = 1'b0;
        repeat (2) @(negedge clk);

        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("completions_left", 32'(comp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
